// File: rtl/pipe_ctrl_if.sv
// Control bus between the pipeline stages and the PC-sequencing controller.
// The counter signals exist only when PIPE_CTRL_PERF_CNT_EN is defined.
interface pipe_ctrl_if;
  logic        load_use;
  logic        br_taken;
  logic [31:0] br_target;
  logic        syscall_wb;
  logic        resume;
  logic        halt;
  logic        pc_bj;
  logic [31:0] pc_src;
  logic        nop_lock_id;
  logic        flush_if_id;
  logic        flush_id_ex;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
  logic [15:0] redirect_cnt;
`endif

  // Pipeline side: raises events, consumes PC control.
  modport master (
    output load_use, br_taken, br_target, syscall_wb, resume,
    input  halt, pc_bj, pc_src, nop_lock_id, flush_if_id, flush_id_ex
`ifdef PIPE_CTRL_PERF_CNT_EN
    , input cycle_cnt, stall_cnt, redirect_cnt
`endif
  );

  // Controller side.
  modport slave (
    input  load_use, br_taken, br_target, syscall_wb, resume,
    output halt, pc_bj, pc_src, nop_lock_id, flush_if_id, flush_id_ex
`ifdef PIPE_CTRL_PERF_CNT_EN
    , output cycle_cnt, stall_cnt, redirect_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// PC-sequencing and hazard controller for the 5-stage pipeline.
// Priority per cycle: syscall_wb > br_taken > load_use. Outputs are
// combinational from state and current inputs.
// Optional performance counters: define PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int LU_STALL = 1
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

  // First stall cycle is spent in RUN, so STALL covers LU_STALL-1 cycles.
  localparam logic [2:0] SCNT_INIT = (LU_STALL > 1) ? 3'(LU_STALL - 2) : 3'd0;

  state_t     state, nstate;
  logic [2:0] scnt, nscnt;
  logic       halt_c, pc_bj_c, nop_c, fif_c, fie_c;

  // State and stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      scnt  <= 3'd0;
    end else begin
      state <= nstate;
      scnt  <= nscnt;
    end
  end

  // Next-state and PC control decode.
  always_comb begin
    nstate  = state;
    nscnt   = scnt;
    halt_c  = 1'b0;
    pc_bj_c = 1'b0;
    nop_c   = 1'b0;
    fif_c   = 1'b0;
    fie_c   = 1'b0;
    case (state)
      RUN, STALL: begin
        if (bus.syscall_wb) begin
          halt_c = 1'b1;
          nstate = HALTED;
        end else if (bus.br_taken) begin
          // A concurrent load_use is dropped: its instruction is squashed.
          pc_bj_c = 1'b1;
          fif_c   = 1'b1;
          fie_c   = 1'b1;
          nstate  = RUN;
        end else if (state == STALL) begin
          nop_c = 1'b1;
          fie_c = 1'b1;
          if (scnt == 3'd0) nstate = RUN;
          else              nscnt  = scnt - 3'd1;
        end else if (bus.load_use) begin
          nop_c = 1'b1;
          fie_c = 1'b1;
          if (LU_STALL > 1) begin
            nstate = STALL;
            nscnt  = SCNT_INIT;
          end
        end
      end
      HALTED: begin
        halt_c = 1'b1;
        if (bus.resume) nstate = RUN;
      end
      default: nstate = RUN;
    endcase
  end

  assign bus.halt        = halt_c;
  assign bus.pc_bj       = pc_bj_c;
  assign bus.pc_src      = pc_bj_c ? bus.br_target : 32'd0;
  assign bus.nop_lock_id = nop_c;
  assign bus.flush_if_id = fif_c;
  assign bus.flush_id_ex = fie_c;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, stall_q;
  logic [15:0] redir_q;

  // Free-running event counters, wrapping at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 32'd0;
      stall_q <= 32'd0;
      redir_q <= 16'd0;
    end else begin
      if (!halt_c) cycle_q <= cycle_q + 32'd1;
      if (nop_c)   stall_q <= stall_q + 32'd1;
      if (pc_bj_c) redir_q <= redir_q + 16'd1;
    end
  end

  assign bus.cycle_cnt    = cycle_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.redirect_cnt = redir_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Two instances run in lockstep on the same
// inputs: dut_a with LU_STALL=3 and dut_b with LU_STALL=4.
// Output vector order: {halt, pc_bj, nop_lock_id, flush_if_id, flush_id_ex}.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_use = 1'b0, br_taken = 1'b0, syscall_wb = 1'b0, resume = 1'b0;
  logic [31:0] br_target = 32'd0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if ifa ();
  pipe_ctrl_if ifb ();

  assign ifa.load_use = load_use;   assign ifb.load_use = load_use;
  assign ifa.br_taken = br_taken;   assign ifb.br_taken = br_taken;
  assign ifa.br_target = br_target; assign ifb.br_target = br_target;
  assign ifa.syscall_wb = syscall_wb; assign ifb.syscall_wb = syscall_wb;
  assign ifa.resume = resume;       assign ifb.resume = resume;

  pipe_ctrl #(.LU_STALL(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_ctrl #(.LU_STALL(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  wire [4:0] oa = {ifa.halt, ifa.pc_bj, ifa.nop_lock_id, ifa.flush_if_id, ifa.flush_id_ex};
  wire [4:0] ob = {ifb.halt, ifb.pc_bj, ifb.nop_lock_id, ifb.flush_if_id, ifb.flush_id_ex};

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_use = 0; br_taken = 0; syscall_wb = 0; resume = 0; br_target = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (oa !== 5'h00) begin $display("FAIL reset_a: got %b want 00000", oa); fails++; end
    tests++;
    if (ob !== 5'h00) begin $display("FAIL reset_b: got %b want 00000", ob); fails++; end
    tests++;
    if (ifa.pc_src !== 32'd0) begin $display("FAIL reset_pc_src: got %h want 0", ifa.pc_src); fails++; end
    tests++;
`ifdef PIPE_CTRL_PERF_CNT_EN
    if ({ifa.cycle_cnt, ifa.stall_cnt, ifa.redirect_cnt} !== 80'd0) begin
      $display("FAIL reset_cnt: got %h/%h/%h want 0", ifa.cycle_cnt, ifa.stall_cnt, ifa.redirect_cnt); fails++;
    end
    tests++;
`endif
    // resume outside HALTED must do nothing and not be remembered
    resume = 1'b1;
    #1;
    if (oa !== 5'h00) begin $display("FAIL resume_run: got %b want 00000", oa); fails++; end
    tests++;
    next();
    resume = 1'b0;
    #1;
    if (oa !== 5'h00) begin $display("FAIL resume_after: got %b want 00000", oa); fails++; end
    tests++;
    next();
  endtask

  task automatic test_branch();
    logic [4:0] e [2] = '{5'h0B, 5'h00};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      br_taken = (i == 0); br_target = (i == 0) ? 32'h40 : 32'h0;
      #1;
      if (oa !== e[i]) begin $display("FAIL branch cyc%0d: got %b want %b", i, oa, e[i]); fails++; end
      tests++;
      if (ifa.pc_src !== (e[i][3] ? 32'h40 : 32'h0)) begin
        $display("FAIL branch_pc_src cyc%0d: got %h want %h", i, ifa.pc_src, e[i][3] ? 32'h40 : 32'h0); fails++;
      end
      tests++;
      next();
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    if (ifa.redirect_cnt !== 16'd1) begin $display("FAIL redirect_cnt: got %0d want 1", ifa.redirect_cnt); fails++; end
    tests++;
`endif
    idle();
  endtask

  task automatic test_stall();
    logic [4:0] ea [4] = '{5'h05, 5'h05, 5'h05, 5'h00};
    logic [4:0] eb [4] = '{5'h05, 5'h05, 5'h05, 5'h05};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load_use = (i == 0);
      #1;
      if (oa !== ea[i]) begin $display("FAIL stall_a cyc%0d: got %b want %b", i, oa, ea[i]); fails++; end
      tests++;
      if (ob !== eb[i]) begin $display("FAIL stall_b cyc%0d: got %b want %b", i, ob, eb[i]); fails++; end
      tests++;
      next();
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    if (ifa.stall_cnt !== 32'd3) begin $display("FAIL stall_cnt_a: got %0d want 3", ifa.stall_cnt); fails++; end
    tests++;
    if (ifb.stall_cnt !== 32'd4) begin $display("FAIL stall_cnt_b: got %0d want 4", ifb.stall_cnt); fails++; end
    tests++;
`endif
    idle();
  endtask

  task automatic test_back_to_back();
    logic [4:0] ea [7] = '{5'h05, 5'h05, 5'h05, 5'h05, 5'h05, 5'h05, 5'h00};
    logic [4:0] eb [7] = '{5'h05, 5'h05, 5'h05, 5'h05, 5'h00, 5'h00, 5'h00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      load_use = (i < 4);
      #1;
      if (oa !== ea[i]) begin $display("FAIL b2b_a cyc%0d: got %b want %b", i, oa, ea[i]); fails++; end
      tests++;
      if (ob !== eb[i]) begin $display("FAIL b2b_b cyc%0d: got %b want %b", i, ob, eb[i]); fails++; end
      tests++;
      next();
    end
    idle();
  endtask

  task automatic test_branch_abort();
    logic [4:0] e [3] = '{5'h05, 5'h0B, 5'h00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_use = (i == 0);
      br_taken = (i == 1);
      br_target = (i == 1) ? 32'h1234 : 32'h0;
      #1;
      if (oa !== e[i]) begin $display("FAIL abort_a cyc%0d: got %b want %b", i, oa, e[i]); fails++; end
      tests++;
      if (ob !== e[i]) begin $display("FAIL abort_b cyc%0d: got %b want %b", i, ob, e[i]); fails++; end
      tests++;
      if (ifb.pc_src !== (e[i][3] ? 32'h1234 : 32'h0)) begin
        $display("FAIL abort_pc_src cyc%0d: got %h want %h", i, ifb.pc_src, e[i][3] ? 32'h1234 : 32'h0); fails++;
      end
      tests++;
      next();
    end
    idle();
  endtask

  task automatic test_halt();
    logic [4:0] e [9] = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00, 5'h00};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      syscall_wb = (i == 0);
      br_taken   = (i == 0) || (i == 3);
      br_target  = br_taken ? 32'h80 : 32'h0;
      load_use   = (i == 4);
      resume     = (i == 6);
      #1;
      if (oa !== e[i]) begin $display("FAIL halt_a cyc%0d: got %b want %b", i, oa, e[i]); fails++; end
      tests++;
      if (ob !== e[i]) begin $display("FAIL halt_b cyc%0d: got %b want %b", i, ob, e[i]); fails++; end
      tests++;
      if (ifa.pc_src !== 32'd0) begin $display("FAIL halt_pc_src cyc%0d: got %h want 0", i, ifa.pc_src); fails++; end
      tests++;
      next();
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    if (ifa.cycle_cnt !== 32'd2) begin $display("FAIL cycle_cnt: got %0d want 2", ifa.cycle_cnt); fails++; end
    tests++;
`endif
    idle();
  endtask

  task automatic test_reset_mid();
    logic [4:0] e [6] = '{5'h10, 5'h10, 5'h00, 5'h05, 5'h05, 5'h00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      syscall_wb = (i == 0);
      load_use   = (i == 3);
      rst        = (i == 1) || (i == 4);
      #1;
      if (oa !== e[i]) begin $display("FAIL rstmid_a cyc%0d: got %b want %b", i, oa, e[i]); fails++; end
      tests++;
      if (ob !== e[i]) begin $display("FAIL rstmid_b cyc%0d: got %b want %b", i, ob, e[i]); fails++; end
      tests++;
      next();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_back_to_back();
    test_branch_abort();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
